queue_occupancy_counter: RTL and testbench
==========================================

Name: queue_occupancy_counter

Overview:
- Upstream stage of the two-digit 7-segment wait-time display decoder.
- Conditions two raw door sensors: the entry sensor marks a person joining, the exit sensor marks a person leaving.
- Keeps a saturating count of people in the queue.
- Produces a registered 5-bit estimated wait time, count × TIME_PER_PERSON, which drives the decoder's wtime input directly.
- Also produces full/empty status and a sticky overflow flag for the board LEDs.

Parameters:
- MAX_COUNT, 7: queue capacity in people. MAX_COUNT*TIME_PER_PERSON must be ≤ 31.
- COUNT_W, 3: width of the count output.
- TIME_PER_PERSON, 3: minutes of wait added per person.
- WTIME_W, 5: wait-time width. Fixed to match the decoder input.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a sensor level change. Board builds override this to 2^20.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- entry_sensor  in  1  raw, asynchronous, bouncy level; high = beam broken at entry.
- exit_sensor  in  1  raw, asynchronous, bouncy level; high = beam broken at exit.
- count  out  COUNT_W  people currently in the queue.
- wtime  out  WTIME_W  count*TIME_PER_PERSON (0,3,6,…,21 at defaults).
- full  out  1  count == MAX_COUNT.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a join was rejected because the queue was full.

Behaviour:
- Reset (asynchronous, any time, including mid-debounce):
  - count=0, wtime=0, empty=1, full=0, overflow=0.
  - Synchronizer flops, debounce counters and debounced levels all clear to 0.
  - A sensor held high through reset release is treated as a fresh level and needs a full debounce before it is accepted.
- Per-sensor conditioning, identical for both sensors:
  - Synchronizer: 2-flop.
  - Debounce FSM, states IDLE_LOW / CONFIRM_HIGH / IDLE_HIGH / CONFIRM_LOW.
  - In a CONFIRM state, a counter increments on each edge at which the synchronized value differs from the debounced level.
  - Any sample equal to the debounced level returns the FSM to the IDLE state and clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the FSM moves to the opposite IDLE state.
  - An event pulse (one cycle) fires on each debounced rising edge only. Falling edges produce no event.
- Latency:
  - Raw input first high at clock edge N and held → debounced level high at edge N+1+DEBOUNCE_CYCLES.
  - Event pulse is high during the following cycle.
  - count and wtime update at edge N+2+DEBOUNCE_CYCLES.
  - At defaults this is 6 edges after N.
- Counter update, on any edge with an event:
  - join only, count<MAX_COUNT → count+1.
  - join only, count==MAX_COUNT → count unchanged; overflow set to 1 and held until reset.
  - leave only, count>0 → count−1.
  - leave only, count==0 → unchanged, no flag (spurious exit).
  - join and leave in the same cycle → count unchanged, including at full and at empty; overflow not set.
- Outputs:
  - wtime, full and empty are registered and computed from the next count value in the same always block, so they change on the same edge as count and never lag it.
  - wtime is computed at WTIME_W bits; the parameter constraint guarantees no truncation.
- A sensor held high indefinitely produces exactly one event.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces none.

Decomposition:
- Shared package (queue_pkg): MAX_COUNT, TIME_PER_PERSON, WTIME_W, COUNT_W, DEBOUNCE_CYCLES defaults, and the 2-bit debounce state encoding. The display decoder and this block both take WTIME_W from the package.
- Sub-module: sensor_conditioner. Contains synchronizer, debounce FSM, counter and rising-edge pulse. It is instantiated twice.
- The top level holds only the saturating counter, the wait-time product and the flags.

Test Plan:
1. Reset release, sensors low → count=0, wtime=0, empty=1, full=0, overflow=0. Assert rst mid-operation at count=4 → all outputs return to reset values asynchronously, before the next clk edge.
2. Entry high for 20 cycles, DEBOUNCE_CYCLES=4 → count 0→1 exactly 6 edges after first high sample, wtime=3, empty=0. Only one increment for the whole high period.
3. Entry pulsed high for 2 cycles, with a 3-cycle high/low chatter pattern → no count change. Follow with a clean 10-cycle pulse → exactly one increment.
4. Eight clean entry pulses from empty → count reaches 7, wtime=21, full=1 after the 7th. The 8th leaves count=7 and sets overflow=1, which stays 1 through subsequent exits.
5. Exit pulse at count=0 → count stays 0, overflow unchanged. At count=7, entry and exit pulses aligned to the same cycle → count stays 7, overflow not set. At count=3, aligned pulses → count stays 3, wtime=9.
6. Sequence join×5, leave×2 → wtime steps 3,6,9,12,15,12,9. Each step coincides with the count change on the same edge.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared constants for the queue wait-time display path.
// The display decoder also takes its wtime width from here.
package queue_pkg;

  localparam int DEF_MAX_COUNT       = 7;
  localparam int DEF_COUNT_W         = 3;
  localparam int DEF_TIME_PER_PERSON = 3;
  localparam int DEF_WTIME_W         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'b00,
    CONFIRM_HIGH = 2'b01,
    IDLE_HIGH    = 2'b11,
    CONFIRM_LOW  = 2'b10
  } deb_state_e;

endpackage

// File: rtl/sensor_conditioner.sv
// One door sensor: 2-flop synchronizer, debounce FSM and a one-cycle pulse
// on each accepted rising level.
//   state        | meaning
//   IDLE_LOW     | debounced low, samples agree
//   CONFIRM_HIGH | debounced low, counting high samples
//   IDLE_HIGH    | debounced high, samples agree
//   CONFIRM_LOW  | debounced high, counting low samples
module sensor_conditioner
  import queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE_LOW:     adv = sync2_q;
      CONFIRM_HIGH: begin
        if (sync2_q) adv = 1'b1;
        else begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      end
      IDLE_HIGH:    adv = !sync2_q;
      CONFIRM_LOW:  begin
        if (!sync2_q) adv = 1'b1;
        else begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
    // Each disagreeing sample counts, including the one that leaves IDLE.
    if (adv) begin
      if (cnt_inc == CNT_TC) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        cnt_d   = '0;
        state_d = level_q ? IDLE_LOW : IDLE_HIGH;
      end else begin
        cnt_d   = cnt_inc;
        state_d = level_q ? CONFIRM_LOW : CONFIRM_HIGH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/queue_occupancy_counter.sv
// Saturating queue occupancy counter with registered wait-time product,
// full/empty status and a sticky overflow flag.
module queue_occupancy_counter
  import queue_pkg::*;
#(
  parameter int MAX_COUNT       = DEF_MAX_COUNT,
  parameter int COUNT_W         = DEF_COUNT_W,
  parameter int TIME_PER_PERSON = DEF_TIME_PER_PERSON,
  parameter int WTIME_W         = DEF_WTIME_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               entry_sensor,
  input  logic               exit_sensor,
  output logic [COUNT_W-1:0] count,
  output logic [WTIME_W-1:0] wtime,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(MAX_COUNT);

  logic               join_evt, leave_evt;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WTIME_W-1:0] wtime_q, wtime_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;

  sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
    .clk      (clk),
    .rst      (rst),
    .sensor_i (entry_sensor),
    .rise_o   (join_evt)
  );

  sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk      (clk),
    .rst      (rst),
    .sensor_i (exit_sensor),
    .rise_o   (leave_evt)
  );

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (join_evt && !leave_evt) begin
      if (count_q < CNT_MAX) count_d = count_q + COUNT_W'(1);
      else                   overflow_d = 1'b1;
    end else if (leave_evt && !join_evt && (count_q != '0)) begin
      count_d = count_q - COUNT_W'(1);
    end
    // Derived from the next count so the flags never lag the count.
    wtime_d = WTIME_W'(count_d) * WTIME_W'(TIME_PER_PERSON);
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wtime_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wtime_q    <= wtime_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign wtime    = wtime_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_queue_occupancy_counter.sv
// Scoreboard bench for queue_occupancy_counter: stimulus pushes expected
// output updates (with the edge they must land on), a monitor pops on change.
module tb_queue_occupancy_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [2:0] count;
  logic [4:0] wtime;
  logic       full;
  logic       empty;
  logic       overflow;

  queue_occupancy_counter dut (
    .clk          (clk),
    .rst          (rst),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .count        (count),
    .wtime        (wtime),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  cnt;
    logic [4:0]  wt;
    logic        f;
    logic        e;
    logic        o;
  } exp_t;

  localparam logic [10:0] RESET_OUTS = {3'd0, 5'd0, 1'b0, 1'b1, 1'b0};

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [10:0] prev_obs = '0;
  logic [10:0] obs;
  exp_t        pop_e;

  bit seq_join[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int seq_cnt[7]  = '{1, 2, 3, 4, 5, 4, 3};
  int seq_wt[7]   = '{3, 6, 9, 12, 15, 12, 9};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] outs();
    return {count, wtime, full, empty, overflow};
  endfunction

  function automatic exp_t mk(input int unsigned at, input int c, input bit o);
    exp_t e;
    e.cyc = at;
    e.cnt = 3'(c);
    e.wt  = 5'(c * 3);
    e.f   = (c == 7);
    e.e   = (c == 0);
    e.o   = o;
    return e;
  endfunction

  always @(negedge clk) begin
    obs = outs();
    if (mon_en && (obs !== prev_obs)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got cnt=%0d wt=%0d f=%0b e=%0b o=%0b, required no change",
                 cyc, count, wtime, full, empty, overflow);
      end else begin
        pop_e = sb_q.pop_front();
        if ((pop_e.cyc != cyc) ||
            ({pop_e.cnt, pop_e.wt, pop_e.f, pop_e.e, pop_e.o} !== obs)) begin
          errors++;
          $display("FAIL sb_update got cyc=%0d cnt=%0d wt=%0d f=%0b e=%0b o=%0b, required cyc=%0d cnt=%0d wt=%0d f=%0b e=%0b o=%0b",
                   cyc, count, wtime, full, empty, overflow,
                   pop_e.cyc, pop_e.cnt, pop_e.wt, pop_e.f, pop_e.e, pop_e.o);
        end
      end
    end
    prev_obs = obs;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at a drive point (1 time unit after an edge). Raw level first
  // sampled at the next edge; count must move 6 edges after that.
  task automatic pulse(input bit j, input bit l, input int len,
                       input int ec, input bit eo, input bit chg);
    int unsigned t0;
    t0 = cyc;
    entry_sensor = j;
    exit_sensor  = l;
    if (chg) sb_q.push_back(mk(t0 + 7, ec, eo));
    step(len);
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    step(12);
  endtask

  task automatic do_reset(input string name);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk(name, int'(outs()), int'(RESET_OUTS));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    entry_sensor = 1'b0;
    exit_sensor  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", int'(outs()), int'(RESET_OUTS));
    rst = 1'b0;
    step(2);
    chk("reset_release", int'(outs()), int'(RESET_OUTS));
    mon_en = 1'b1;

    // Long high: one increment, 6 edges after first sample
    pulse(1'b1, 1'b0, 20, 1, 1'b0, 1'b1);
    chk("t2_count", int'(count), 1);
    chk("t2_wtime", int'(wtime), 3);
    chk("t2_empty", int'(empty), 0);

    // Glitch and chatter: no change
    entry_sensor = 1'b1; step(2);
    entry_sensor = 1'b0; step(10);
    repeat (3) begin
      entry_sensor = 1'b1; step(3);
      entry_sensor = 1'b0; step(1);
    end
    step(10);
    chk("t3_no_change", int'(count), 1);
    pulse(1'b1, 1'b0, 10, 2, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 10, 3, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 10, 4, 1'b0, 1'b1);
    chk("t1_count4", int'(count), 4);

    // Async reset mid-debounce with entry held high through release
    entry_sensor = 1'b1;
    step(2);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("t1_async_reset", int'(outs()), int'(RESET_OUTS));
    @(posedge clk); #1;
    step(1);
    rst    = 1'b0;
    mon_en = 1'b1;
    sb_q.push_back(mk(cyc + 7, 1, 1'b0));
    step(10);
    entry_sensor = 1'b0;
    step(12);
    chk("t1_held_through_reset", int'(count), 1);

    // Fill, aligned at full, overflow, drain
    do_reset("t4_reset");
    pulse(1'b0, 1'b1, 10, 0, 1'b0, 1'b0);
    chk("t5_exit_empty_cnt", int'(count), 0);
    chk("t5_exit_empty_ovf", int'(overflow), 0);
    for (int i = 1; i <= 7; i++) pulse(1'b1, 1'b0, 10, i, 1'b0, 1'b1);
    chk("t4_full", int'(full), 1);
    chk("t4_wtime21", int'(wtime), 21);
    pulse(1'b1, 1'b1, 10, 7, 1'b0, 1'b0);
    chk("t5_aligned_full_cnt", int'(count), 7);
    chk("t5_aligned_full_ovf", int'(overflow), 0);
    pulse(1'b1, 1'b0, 10, 7, 1'b1, 1'b1);
    chk("t4_overflow", int'(overflow), 1);
    for (int i = 6; i >= 3; i--) pulse(1'b0, 1'b1, 10, i, 1'b1, 1'b1);
    chk("t4_overflow_sticky", int'(overflow), 1);
    pulse(1'b1, 1'b1, 10, 3, 1'b1, 1'b0);
    chk("t5_aligned3_cnt", int'(count), 3);
    chk("t5_aligned3_wtime", int'(wtime), 9);

    // join x5, leave x2
    do_reset("t6_reset");
    for (int i = 0; i < 7; i++) begin
      pulse(seq_join[i], !seq_join[i], 10, seq_cnt[i], 1'b0, 1'b1);
      chk("t6_wtime", int'(wtime), seq_wt[i]);
    end

    step(5);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending updates required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
